// File: rtl/multicycle_ls_core.sv
// rtl/multicycle_ls_core.sv - multicycle LW/SW/R-type core with local RF, DM and probes
// One instruction in flight at a time, sequenced IDLE -> DECODE -> EXEC -> [MEM] -> WB.
module multicycle_ls_core #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5,
  parameter int DM_ADDR_W = 8,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 dbg_we,
  input  logic [DM_ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0]    dbg_wdata,
  input  logic [RF_ADDR_W-1:0] rf_probe_idx,
  input  logic [DM_ADDR_W-1:0] dm_probe_idx,
  output logic [DATA_W-1:0]    rf_probe,
  output logic [DATA_W-1:0]    dm_probe,
  output logic [DATA_W-1:0]    alu_result,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  state_t              state;
  logic [31:0]         instr_q;
  logic [DATA_W-1:0]   a_q, b_q, load_q;
  logic                err_q;
  logic [DATA_W-1:0]   rf [2**RF_ADDR_W];
  logic [DATA_W-1:0]   dm [2**DM_ADDR_W];

  logic [5:0]           op;
  logic                 reg_dst, alu_src, mem_to_reg;
  logic [2:0]           alu_ctl;
  logic [RF_ADDR_W-1:0] rs_idx, rt_idx, rd_idx;
  logic [DATA_W-1:0]    sign_imm, opnd, alu_out;
  logic                 is_lw, is_sw, is_r, alu_ok, legal, addr_oob;
  logic [DM_ADDR_W-1:0] dm_idx;

  assign op         = instr_q[31:26];
  assign reg_dst    = op[5];
  assign alu_src    = op[4];
  assign alu_ctl    = op[3:1];
  assign mem_to_reg = op[0];
  assign rs_idx     = instr_q[21 +: RF_ADDR_W];
  assign rt_idx     = instr_q[16 +: RF_ADDR_W];
  assign rd_idx     = instr_q[11 +: RF_ADDR_W];
  assign sign_imm   = DATA_W'($signed(instr_q[15:0]));

  assign is_lw  = !reg_dst &&  alu_src &&  mem_to_reg;
  assign is_sw  = !reg_dst &&  alu_src && !mem_to_reg;
  assign is_r   =  reg_dst && !alu_src && !mem_to_reg;
  assign alu_ok = alu_ctl inside {3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  assign legal  = (is_lw || is_sw || is_r) && alu_ok;

  assign opnd = alu_src ? sign_imm : b_q;

  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      3'b010:  alu_out = a_q + opnd;
      3'b110:  alu_out = a_q - opnd;
      3'b000:  alu_out = a_q & opnd;
      3'b001:  alu_out = a_q | opnd;
      3'b111:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(opnd))};
      default: alu_out = '0;
    endcase
  end

  // Any set bit above the DM index field means the word address does not exist.
  assign addr_oob = (alu_result >> DM_ADDR_W) != '0;
  assign dm_idx   = alu_result[DM_ADDR_W-1:0];

  assign instr_ready = (state == IDLE);
  assign rf_probe    = rf[rf_probe_idx];
  assign dm_probe    = dm[dm_probe_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      instr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      load_q     <= '0;
      err_q      <= 1'b0;
      alu_result <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      retired    <= '0;
      for (int i = 0; i < 2**RF_ADDR_W; i++) rf[i] <= '0;
      for (int i = 0; i < 2**DM_ADDR_W; i++) dm[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_we) dm[dbg_addr] <= dbg_wdata;
          if (instr_valid) begin
            instr_q <= instr;
            err_q   <= 1'b0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rf[rs_idx];
          b_q <= rf[rt_idx];
          if (!legal) begin
            err_q <= 1'b1;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= WB;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_result <= alu_out;
          if (is_r) begin
            done  <= 1'b1;
            state <= WB;
          end else begin
            state <= MEM;
          end
        end
        MEM: begin
          if (addr_oob) err_q <= 1'b1;
          else if (is_lw) load_q <= dm[dm_idx];
          else dm[dm_idx] <= b_q;
          done  <= 1'b1;
          err   <= addr_oob;
          state <= WB;
        end
        WB: begin
          // RF[0] is never written, so it reads as zero from reset onward.
          if (!err_q) begin
            if (is_lw && rt_idx != '0) rf[rt_idx] <= load_q;
            if (is_r && rd_idx != '0) rf[rd_idx] <= alu_result;
            retired <= retired + CNT_W'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ls_core.sv
// tb/tb_multicycle_ls_core.sv - directed self-checking bench for multicycle_ls_core
module tb_multicycle_ls_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        dbg_we;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic [4:0]  rf_probe_idx;
  logic [7:0]  dm_probe_idx;
  logic [31:0] rf_probe;
  logic [31:0] dm_probe;
  logic [31:0] alu_result;
  logic        done;
  logic        err;
  logic [15:0] retired;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_ls_core dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .rf_probe_idx(rf_probe_idx), .dm_probe_idx(dm_probe_idx),
    .rf_probe(rf_probe), .dm_probe(dm_probe), .alu_result(alu_result),
    .done(done), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    rf_probe_idx = idx;
    @(negedge clk);
    check(tag, rf_probe, exp);
  endtask

  task automatic chk_dm(input logic [7:0] idx, input logic [31:0] exp, input string tag);
    dm_probe_idx = idx;
    @(negedge clk);
    check(tag, dm_probe, exp);
  endtask

  task automatic dbg_write(input logic [7:0] a, input logic [31:0] d);
    tick();
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    tick();
    dbg_we = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  // Present one instruction, measure cycles from the accept edge to done, check err.
  task automatic run_instr(input logic [31:0] ins, input int lat, input logic e, input string tag);
    int k;
    tick();
    check({tag, " ready"}, instr_ready, 1'b1);
    instr = ins; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    k = 1;
    while (!done && k < 20) begin tick(); k++; end
    check({tag, " latency"}, k, lat);
    check({tag, " err"}, err, e);
    tick();
    check({tag, " done one cycle"}, done, 1'b0);
  endtask

  initial begin
    int k;
    int pulses;
    rst = 1'b0; instr = '0; instr_valid = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0; rf_probe_idx = '0; dm_probe_idx = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("reset ready", instr_ready, 1'b1);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset retired", retired, 16'd0);
    check("reset alu", alu_result, 32'd0);

    // 1: preload and LW
    dbg_write(8'd5, 32'hDEADBEEF);
    chk_dm(8'd5, 32'hDEADBEEF, "dbg dm5");
    run_instr(32'h54010005, 4, 1'b0, "lw1");
    chk_rf(5'd1, 32'hDEADBEEF, "lw1 rf1");
    check("lw1 alu", alu_result, 32'd5);
    check("lw1 retired", retired, 16'd1);

    // 2: SW
    run_instr(32'h50010002, 4, 1'b0, "sw1");
    chk_dm(8'd2, 32'hDEADBEEF, "sw1 dm2");
    chk_rf(5'd2, 32'd0, "sw1 rf2");
    check("sw1 retired", retired, 16'd2);

    // 3: R-type ops
    run_instr(32'h90211800, 3, 1'b0, "add");
    chk_rf(5'd3, 32'hBD5B7DDE, "add rf3");
    run_instr(32'h90210000, 3, 1'b0, "add rd0");
    chk_rf(5'd0, 32'd0, "add rd0 rf0");
    check("add rd0 retired", retired, 16'd4);
    run_instr(enc_r(6'h2C, 5'd1, 5'd3, 5'd4), 3, 1'b0, "sub");
    chk_rf(5'd4, 32'h21524111, "sub rf4");
    run_instr(enc_r(6'h2E, 5'd3, 5'd4, 5'd5), 3, 1'b0, "slt");
    chk_rf(5'd5, 32'd1, "slt rf5");
    run_instr(enc_r(6'h20, 5'd1, 5'd3, 5'd6), 3, 1'b0, "and");
    chk_rf(5'd6, 32'h9C093CCE, "and rf6");
    run_instr(enc_r(6'h22, 5'd1, 5'd3, 5'd7), 3, 1'b0, "or");
    chk_rf(5'd7, 32'hFFFFFFFF, "or rf7");
    check("r retired", retired, 16'd8);

    // 4: errors and address boundary
    run_instr(32'h00000000, 2, 1'b1, "illegal");
    check("illegal alu kept", alu_result, 32'hFFFFFFFF);
    check("illegal retired", retired, 16'd8);
    run_instr(enc_i(6'h15, 5'd0, 5'd2, 16'h0100), 4, 1'b1, "lw oob");
    chk_rf(5'd2, 32'd0, "lw oob rf2");
    check("lw oob alu", alu_result, 32'h00000100);
    run_instr(enc_i(6'h17, 5'd0, 5'd2, 16'h0005), 2, 1'b1, "bad aluctl");
    run_instr(enc_i(6'h14, 5'd0, 5'd1, 16'hFFFF), 4, 1'b1, "sw neg oob");
    chk_dm(8'hFF, 32'd0, "sw neg oob dm255");
    check("err retired", retired, 16'd8);
    dbg_write(8'hFF, 32'h0BADF00D);
    run_instr(enc_i(6'h15, 5'd0, 5'd8, 16'h00FF), 4, 1'b0, "lw 255");
    chk_rf(5'd8, 32'h0BADF00D, "lw 255 rf8");
    check("lw 255 retired", retired, 16'd9);

    // 5: valid held high, debug writes while busy
    tick();
    instr = enc_i(6'h15, 5'd0, 5'd9, 16'h0005); instr_valid = 1'b1;
    tick();
    dbg_we = 1'b1; dbg_addr = 8'd6; dbg_wdata = 32'h12345678;
    k = 1;
    while (!done && k < 20) begin tick(); k++; end
    check("hold lw latency", k, 4);
    dbg_we = 1'b0;
    tick();
    check("hold idle ready", instr_ready, 1'b1);
    check("hold retired a", retired, 16'd10);
    dbg_we = 1'b1; dbg_addr = 8'd7; dbg_wdata = 32'hA5A5A5A5;
    tick();
    dbg_we = 1'b0; instr_valid = 1'b0;
    check("hold reaccept busy", instr_ready, 1'b0);
    k = 1;
    while (!done && k < 20) begin tick(); k++; end
    check("hold lw2 latency", k, 4);
    tick();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) pulses++; end
    check("hold extra accepts", pulses, 0);
    check("hold retired b", retired, 16'd11);
    chk_rf(5'd9, 32'hDEADBEEF, "hold rf9");
    chk_dm(8'd6, 32'd0, "busy dbg ignored");
    chk_dm(8'd7, 32'hA5A5A5A5, "dbg with accept");

    // 6: reset during MEM of SW to DM[2]
    tick();
    instr = 32'h50010002; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst mem ready", instr_ready, 1'b1);
    check("rst mem done", done, 1'b0);
    check("rst mem retired", retired, 16'd0);
    check("rst mem alu", alu_result, 32'd0);
    chk_dm(8'd2, 32'd0, "rst mem dm2");
    chk_rf(5'd1, 32'd0, "rst mem rf1");
    pulses = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done) pulses++; end
    check("rst mem no done", pulses, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
